sobel_result_writer: RTL and testbench

SOBEL_RESULT_WRITER -- requirements
Module: sobel_result_writer

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_write_fifo.sv | 70 +++++++
 rtl/sobel_result_writer.sv | 157 +++++++++++++++
 tb/tb_sobel_result_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sobel_pkg
// Description : Shared definitions for the Sobel result writer. This package
//               holds the writer state encoding, the packed word width and
//               the number of pixels packed into each word.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

  localparam int WORD_W          = 64;
  localparam int PIXEL_W         = 8;
  localparam int PIXELS_PER_WORD = 8;
  localparam int IDX_W           = $clog2(PIXELS_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sobel_write_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sobel_write_fifo
// Description : Synchronous FIFO that holds packed pixel words waiting to be
//               written to memory. A push and a pop can happen in the same
//               cycle, including when the FIFO is full. When it is full, a
//               push is taken only if a pop frees a slot in that cycle.
//               clear empties the FIFO and takes priority over push and pop.
// Ports       : clk, reset      - clock and synchronous active-high reset
//               clear           - synchronous discard of all entries
//               push, push_data - write request and word
//               pop             - removes the head (ignored when empty)
//               head            - current head word (0 when empty)
//               count           - number of stored entries
//               full, empty     - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sobel_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_result_writer
// Description : Packs 8-bit Sobel magnitude pixels into 64-bit words, with the
//               first pixel in the lowest byte. Completed words are queued in
//               a small FIFO and written to consecutive word addresses from
//               STARTADDRESS to ENDADDRESS. flush ends the frame early and
//               zero-pads any partial word. The write at ENDADDRESS ends the
//               frame and discards any data that is still buffered.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               start, flush         - frame control pulses
//               pixelIn/Valid/Ready  - pixel input handshake
//               writeReady/En        - memory write handshake
//               writeData, writeAddr - packed word and its word address
//               busy, done           - frame status
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_result_writer
  import sobel_pkg::*;
#(
  parameter int STARTADDRESS = 0,
  parameter int ENDADDRESS   = 2097151,
  parameter int ADDRW        = 24,
  parameter int FIFODEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               flush,
  input  logic [PIXEL_W-1:0] pixelIn,
  input  logic               pixelValid,
  output logic               pixelReady,
  input  logic               writeReady,
  output logic               writeEn,
  output logic [WORD_W-1:0]  writeData,
  output logic [ADDRW-1:0]   writeAddr,
  output logic               busy,
  output logic               done
);

  localparam int CNTW = $clog2(FIFODEPTH) + 1;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] merged;
  logic [WORD_W-1:0] push_data;
  logic [CNTW-1:0]   count;
  logic              full;
  logic              empty;
  logic              in_run;
  logic              in_flush;
  logic              accept;
  logic              wr_fire;
  logic              end_hit;
  logic              start_load;
  logic              word_push;
  logic              pad_push;
  logic              fifo_push;
  logic              fifo_clear;

  assign in_run     = (state == ST_RUN);
  assign in_flush   = (state == ST_FLUSH);
  assign pixelReady = in_run && (count < CNTW'(FIFODEPTH));
  assign accept     = pixelValid && pixelReady;
  assign writeEn    = !empty && (in_run || in_flush);
  assign wr_fire    = writeEn && writeReady;
  assign end_hit    = wr_fire && (writeAddr == ADDRW'(ENDADDRESS));
  assign start_load = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign word_push  = accept && (idx == IDX_W'(PIXELS_PER_WORD - 1));
  // The padding word may take the slot freed by a pop in the same cycle.
  assign pad_push   = in_flush && (idx != '0) && (!full || wr_fire);
  assign fifo_push  = word_push || pad_push;
  assign fifo_clear = end_hit || start_load;
  assign push_data  = in_flush ? word : merged;
  assign busy       = in_run || in_flush;
  assign done       = (state == ST_DONE);

  // Add the incoming pixel to the partial word at the current byte index.
  always_comb begin
    merged = word;
    merged[{idx, 3'b000} +: PIXEL_W] = pixelIn;
  end

  sobel_write_fifo #(
    .DEPTH (FIFODEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (wr_fire),
    .head      (writeData),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      word      <= '0;
      writeAddr <= ADDRW'(STARTADDRESS);
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            idx       <= '0;
            word      <= '0;
            writeAddr <= ADDRW'(STARTADDRESS);
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (word_push) begin
              idx  <= '0;
              word <= '0;
            end else begin
              idx  <= idx + IDX_W'(1);
              word <= merged;
            end
          end
          if (wr_fire) writeAddr <= writeAddr + ADDRW'(1);
          // The last write ends the frame even if flush is raised in the same cycle.
          if (end_hit) begin
            state <= ST_DONE;
            idx   <= '0;
            word  <= '0;
          end else if (flush) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (pad_push) begin
            idx  <= '0;
            word <= '0;
          end
          if (wr_fire) writeAddr <= writeAddr + ADDRW'(1);
          if (end_hit) begin
            state <= ST_DONE;
            idx   <= '0;
            word  <= '0;
          end else if (empty && (idx == '0)) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_result_writer
// Description : Scoreboard bench for sobel_result_writer. Instance dut uses
//               the default parameters, and instance dut_end uses
//               ENDADDRESS=3. The stimulus pushes each expected
//               (address, word) pair into a queue. A monitor for each instance
//               pops that queue on every write transfer and compares the
//               transfer against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_result_writer;

  logic        clk = 1'b0;
  logic        reset, start, e_start, flush, pixelValid, writeReady;
  logic [7:0]  pixelIn;
  logic        pixelReady, writeEn, busy, done;
  logic [63:0] writeData;
  logic [23:0] writeAddr;
  logic        e_pixelReady, e_writeEn, e_busy, e_done;
  logic [63:0] e_writeData;
  logic [23:0] e_writeAddr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_a[$];
  logic [63:0] exp_d[$];
  logic [23:0] e_exp_a[$];
  logic [63:0] e_exp_d[$];

  always #5 clk = ~clk;

  sobel_result_writer dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .pixelIn(pixelIn), .pixelValid(pixelValid), .pixelReady(pixelReady),
    .writeReady(writeReady), .writeEn(writeEn), .writeData(writeData),
    .writeAddr(writeAddr), .busy(busy), .done(done)
  );

  sobel_result_writer #(.ENDADDRESS(3)) dut_end (
    .clk(clk), .reset(reset), .start(e_start), .flush(flush),
    .pixelIn(pixelIn), .pixelValid(pixelValid), .pixelReady(e_pixelReady),
    .writeReady(writeReady), .writeEn(e_writeEn), .writeData(e_writeData),
    .writeAddr(e_writeAddr), .busy(e_busy), .done(e_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input logic [7:0] b);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = b + 8'(j);
    return w;
  endfunction

  // Monitor for the default instance: write transfers and hold stability.
  logic        stall_p = 1'b0;
  logic [63:0] d_p;
  logic [23:0] a_p;
  always @(negedge clk) begin
    if (reset) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p && writeEn) begin
        chk("hold_data", writeData, d_p);
        chk("hold_addr", 64'(writeAddr), 64'(a_p));
      end
      if (writeEn && writeReady) begin
        if (exp_d.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h, expected no write", writeAddr, writeData);
        end else begin
          chk("write_addr", 64'(writeAddr), 64'(exp_a.pop_front()));
          chk("write_data", writeData, exp_d.pop_front());
        end
      end
      stall_p = writeEn && !writeReady;
      d_p     = writeData;
      a_p     = writeAddr;
    end
  end

  // Monitor for the ENDADDRESS=3 instance.
  always @(negedge clk) begin
    if (!reset && e_writeEn && writeReady) begin
      if (e_exp_d.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL e_unexpected_write: addr %h data %h, expected no write", e_writeAddr, e_writeData);
      end else begin
        chk("e_write_addr", 64'(e_writeAddr), 64'(e_exp_a.pop_front()));
        chk("e_write_data", e_writeData, e_exp_d.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input bit sel, input logic [23:0] a, input logic [63:0] d);
    if (sel) begin e_exp_a.push_back(a); e_exp_d.push_back(d); end
    else     begin exp_a.push_back(a);   exp_d.push_back(d);   end
  endtask

  // Offer one pixel until it is accepted. For sel=1, stop offering once
  // dut_end reports done.
  task automatic send_pix(input bit sel, input logic [7:0] p, output bit acc);
    int n = 0;
    acc        = 1'b0;
    pixelIn    = p;
    pixelValid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (sel ? e_pixelReady : pixelReady) begin acc = 1'b1; break; end
      if (sel && e_done) break;
      n++;
      if (n > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL pixel_timeout: pixel %h not accepted after %0d cycles, expected acceptance", p, n);
        break;
      end
    end
    sync();
    pixelValid = 1'b0;
  endtask

  task automatic send_run(input bit sel, input logic [7:0] base, input int n);
    bit acc;
    for (int i = 0; i < n; i++) send_pix(sel, base + 8'(i), acc);
  endtask

  task automatic wait_drain(input bit sel);
    int n = 0;
    while (((sel ? e_exp_d.size() : exp_d.size()) > 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d writes outstanding, expected 0", sel ? e_exp_d.size() : exp_d.size());
    end
    sync();
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) e_start = 1'b1; else start = 1'b1;
    sync();
    e_start = 1'b0;
    start   = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    sync();
    flush = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset = 1'b1; start = 1'b0; e_start = 1'b0; flush = 1'b0;
    pixelIn = '0; pixelValid = 1'b0; writeReady = 1'b0;

    // Check outputs while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pixelReady", 64'(pixelReady), 64'd0);
    chk("rst_writeEn",    64'(writeEn),    64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_done",       64'(done),       64'd0);
    chk("rst_writeAddr",  64'(writeAddr),  64'd0);
    chk("rst_writeData",  writeData,       64'd0);
    chk("rst_e_writeEn",  64'(e_writeEn),  64'd0);
    sync();
    reset = 1'b0;

    // Basic packing: 16 pixels produce two words.
    writeReady = 1'b1;
    pulse_start(0);
    @(negedge clk);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_addr", 64'(writeAddr), 64'd0);
    sync();
    exp_push(0, 24'd0, 64'h0807060504030201);
    exp_push(0, 24'd1, 64'h100F0E0D0C0B0A09);
    send_run(0, 8'h01, 16);
    wait_drain(0);
    @(negedge clk);
    chk("busy_after_words", 64'(busy), 64'd1);
    sync();
    pulse_flush();
    idle(3);
    @(negedge clk);
    chk("flush_empty_done", 64'(done), 64'd1);
    chk("flush_empty_busy", 64'(busy), 64'd0);
    sync();

    // Backpressure: 40 pixels with writeReady low.
    pulse_start(0);
    writeReady = 1'b0;
    for (int k = 0; k < 5; k++) exp_push(0, 24'(k), mkword(8'(1 + 8*k)));
    fork
      send_run(0, 8'h01, 40);
      begin
        repeat (60) @(negedge clk);
        chk("bp_pixelReady", 64'(pixelReady), 64'd0);
        chk("bp_writeEn",    64'(writeEn),    64'd1);
        chk("bp_addr",       64'(writeAddr),  64'd0);
        chk("bp_data",       writeData,       mkword(8'h01));
        repeat (5) @(negedge clk);
        chk("bp_addr_hold",  64'(writeAddr),  64'd0);
        chk("bp_data_hold",  writeData,       mkword(8'h01));
        sync();
        writeReady = 1'b1;
      end
    join
    wait_drain(0);
    pulse_flush();
    idle(3);

    // Partial word followed by flush.
    pulse_start(0);
    exp_push(0, 24'd0, 64'h0000000000CCBBAA);
    send_pix(0, 8'hAA, acc);
    send_pix(0, 8'hBB, acc);
    send_pix(0, 8'hCC, acc);
    pulse_flush();
    wait_drain(0);
    idle(3);
    @(negedge clk);
    chk("pad_done",    64'(done),    64'd1);
    chk("pad_writeEn", 64'(writeEn), 64'd0);
    sync();

    // ENDADDRESS=3: only addresses 0..3 are written, the rest is discarded.
    writeReady = 1'b0;
    pulse_start(1);
    for (int k = 0; k < 4; k++) exp_push(1, 24'(k), mkword(8'(1 + 8*k)));
    fork
      begin
        for (int i = 1; i <= 40; i++) begin
          send_pix(1, 8'(i), acc);
          if (!acc) break;
        end
      end
      begin
        repeat (50) @(negedge clk);
        sync();
        writeReady = 1'b1;
      end
    join
    idle(3);
    @(negedge clk);
    chk("end_done",       64'(e_done),         64'd1);
    chk("end_pixelReady", 64'(e_pixelReady),   64'd0);
    chk("end_writeEn",    64'(e_writeEn),      64'd0);
    chk("end_writes_left", 64'(e_exp_d.size()), 64'd0);
    sync();

    // Reset mid-frame with two words queued.
    pulse_start(0);
    writeReady = 1'b0;
    send_run(0, 8'h51, 16);
    @(negedge clk);
    chk("mid_queued_writeEn", 64'(writeEn), 64'd1);
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_writeEn", 64'(writeEn), 64'd0);
    end
    chk("mid_rst_busy", 64'(busy), 64'd0);
    sync();
    writeReady = 1'b1;
    pulse_start(0);
    exp_push(0, 24'd0, mkword(8'h21));
    send_run(0, 8'h21, 8);
    wait_drain(0);
    pulse_flush();
    idle(3);

    // Full FIFO draining while pixels stream in, then flush with a pad
    // push and a pop in the same cycle at count 3.
    pulse_start(0);
    writeReady = 1'b0;
    for (int k = 0; k < 6; k++) exp_push(0, 24'(k), mkword(8'(8'h41 + 8*k)));
    fork
      send_run(0, 8'h41, 48);
      begin
        repeat (80) @(negedge clk);
        chk("full_pixelReady", 64'(pixelReady), 64'd0);
        chk("full_writeEn",    64'(writeEn),    64'd1);
        chk("full_head",       writeData,       mkword(8'h41));
        sync();
        writeReady = 1'b1;
      end
    join
    wait_drain(0);
    writeReady = 1'b0;
    for (int k = 0; k < 3; k++) exp_push(0, 24'(6 + k), mkword(8'(8'h71 + 8*k)));
    send_run(0, 8'h71, 24);
    exp_push(0, 24'd9, 64'h0000000000D3D2D1);
    send_run(0, 8'hD1, 3);
    @(negedge clk);
    chk("three_queued_ready", 64'(pixelReady), 64'd1);
    sync();
    flush = 1'b1;
    sync();
    flush = 1'b0;
    writeReady = 1'b1;
    wait_drain(0);
    idle(3);
    @(negedge clk);
    chk("final_done", 64'(done), 64'd1);
    sync();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
